// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if: requester handshakes and RAM-side bus
// of the shared byte-wide memory port scheduler.
interface mem_port_sched_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_wid;
    logic              ld_sign;
    logic              ld_done;
    logic [31:0]       ld_data;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_wid;
    logic [31:0]       st_data;
    logic              st_done;
    logic              busy;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;

    modport master (
        output if_req, if_addr,
        output ld_req, ld_addr, ld_wid, ld_sign,
        output st_req, st_addr, st_wid, st_data,
        output mem_din,
        input  if_done, if_data,
        input  ld_done, ld_data,
        input  st_done, busy,
        input  mem_a, mem_wr, mem_dout
    );

    modport slave (
        input  if_req, if_addr,
        input  ld_req, ld_addr, ld_wid, ld_sign,
        input  st_req, st_addr, st_wid, st_data,
        input  mem_din,
        output if_done, if_data,
        output ld_done, ld_data,
        output st_done, busy,
        output mem_a, mem_wr, mem_dout
    );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates fetch/load/store onto one byte-wide
// RAM port and sequences each transaction as byte accesses.
module mem_port_sched #(
    parameter int ADDR_W  = 32,
    parameter int AGE_MAX = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             rdy,
    input logic             clr,
    mem_port_sched_if.slave bus
);
    localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [2:0]        len, len_nx;
    logic [AGE_W-1:0]  age, age_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic              sign, sign_nx;
    logic              fetch, fetch_nx;
    logic [31:0]       wdata, wdata_nx;
    logic [31:0]       asm_q, asm_nx;
    logic [31:0]       if_word, if_word_nx;
    logic [31:0]       ld_word, ld_word_nx;
    logic              if_dq, if_dq_nx;
    logic              ld_dq, ld_dq_nx;
    logic              st_dq, st_dq_nx;

    logic              if_ok, ld_ok, st_ok, st_old;
    logic              g_if, g_ld, g_st;
    logic [31:0]       asm_word;

    function automatic logic [2:0] width_len(input logic [1:0] wid);
        logic [2:0] r;
        unique case (wid)
            2'd0:    r = 3'd1;
            2'd1:    r = 3'd2;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] w,
        input logic [2:0]  n,
        input logic        s
    );
        logic [31:0] r;
        unique case (n)
            3'd1:    r = {{24{s & w[7]}}, w[7:0]};
            3'd2:    r = {{16{s & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Qualify requests (done-masked, flush-masked) and pick one
    always_comb begin
        if_ok  = bus.if_req & ~if_dq & ~clr;
        ld_ok  = bus.ld_req & ~ld_dq & ~clr;
        st_ok  = bus.st_req & ~st_dq;
        st_old = st_ok && (age == AGE_TOP);
        g_if   = 1'b0;
        g_ld   = 1'b0;
        g_st   = 1'b0;
        if (state == IDLE) begin
            if (st_old)     g_st = 1'b1;
            else if (ld_ok) g_ld = 1'b1;
            else if (if_ok) g_if = 1'b1;
            else if (st_ok) g_st = 1'b1;
        end
    end

    // Merge the byte returned for the previous address into the word
    always_comb begin
        asm_word = asm_q;
        for (int i = 0; i < 4; i++) begin
            if (cnt == 3'(i + 1)) asm_word[8*i +: 8] = bus.mem_din;
        end
    end

    // Next-state, sequencing and completion logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        len_nx     = len;
        base_nx    = base;
        sign_nx    = sign;
        fetch_nx   = fetch;
        wdata_nx   = wdata;
        asm_nx     = asm_q;
        if_word_nx = if_word;
        ld_word_nx = ld_word;
        if_dq_nx   = 1'b0;
        ld_dq_nx   = 1'b0;
        st_dq_nx   = 1'b0;
        age_nx     = age;

        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                asm_nx = '0;
                if (g_ld) begin
                    state_nx = RD;
                    base_nx  = bus.ld_addr;
                    len_nx   = width_len(bus.ld_wid);
                    sign_nx  = bus.ld_sign;
                    fetch_nx = 1'b0;
                end else if (g_if) begin
                    state_nx = RD;
                    base_nx  = bus.if_addr;
                    len_nx   = 3'd4;
                    sign_nx  = 1'b0;
                    fetch_nx = 1'b1;
                end else if (g_st) begin
                    state_nx = WR;
                    base_nx  = bus.st_addr;
                    len_nx   = width_len(bus.st_wid);
                    wdata_nx = bus.st_data;
                end
            end
            RD: begin
                if (clr) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == len) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    if (fetch) begin
                        if_dq_nx   = 1'b1;
                        if_word_nx = asm_word;
                    end else begin
                        ld_dq_nx   = 1'b1;
                        ld_word_nx = extend(asm_word, len, sign);
                    end
                end else begin
                    cnt_nx = cnt + 3'd1;
                    asm_nx = asm_word;
                end
            end
            WR: begin
                if (cnt == len - 3'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    st_dq_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // A waiting store gains age each time someone else is granted
        if (!bus.st_req || g_st) begin
            age_nx = '0;
        end else if ((g_ld || g_if) && age != AGE_TOP) begin
            age_nx = age + 1'b1;
        end
    end

    // State registers; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            len     <= '0;
            age     <= '0;
            base    <= '0;
            sign    <= 1'b0;
            fetch   <= 1'b0;
            wdata   <= '0;
            asm_q   <= '0;
            if_word <= '0;
            ld_word <= '0;
            if_dq   <= 1'b0;
            ld_dq   <= 1'b0;
            st_dq   <= 1'b0;
        end else if (rdy) begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            len     <= len_nx;
            age     <= age_nx;
            base    <= base_nx;
            sign    <= sign_nx;
            fetch   <= fetch_nx;
            wdata   <= wdata_nx;
            asm_q   <= asm_nx;
            if_word <= if_word_nx;
            ld_word <= ld_word_nx;
            if_dq   <= if_dq_nx;
            ld_dq   <= ld_dq_nx;
            st_dq   <= st_dq_nx;
        end
    end

    // RAM port drive; idle outputs are held at zero
    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;
        if (state == WR) begin
            bus.mem_a  = base + ADDR_W'(cnt);
            bus.mem_wr = rdy;
            for (int i = 0; i < 4; i++) begin
                if (cnt == 3'(i)) bus.mem_dout = wdata[8*i +: 8];
            end
        end else if (state == RD && cnt != len) begin
            bus.mem_a = base + ADDR_W'(cnt);
        end
    end

    assign bus.if_done = if_dq & rdy;
    assign bus.ld_done = ld_dq & rdy;
    assign bus.st_done = st_dq & rdy;
    assign bus.if_data = if_word;
    assign bus.ld_data = ld_word;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: directed checks of arbitration, byte sequencing,
// aging, flush and stall behaviour against a small byte RAM.
module tb_mem_port_sched;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0]  ram [256];
    logic [31:0] wa  [4];
    logic [7:0]  wd  [4];

    mem_port_sched_if #(.ADDR_W(32)) bus ();

    mem_port_sched #(.ADDR_W(32), .AGE_MAX(2)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Registered-read byte RAM, frozen by the global enable
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h00] <= 8'h13;
            ram[8'h01] <= 8'h05;
            ram[8'h20] <= 8'h80;
            ram[8'h22] <= 8'h01;
            ram[8'h23] <= 8'h80;
            ram[8'h30] <= 8'h5A;
            ram[8'h40] <= 8'h11;
            ram[8'h41] <= 8'h22;
            ram[8'h42] <= 8'h33;
            ram[8'h43] <= 8'h44;
            bus.mem_din <= 8'h00;
        end else if (rdy) begin
            bus.mem_din <= ram[bus.mem_a[7:0]];
            if (bus.mem_wr) ram[bus.mem_a[7:0]] <= bus.mem_dout;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wa = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        wd = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.ld_req  = 1'b0;
        bus.ld_addr = '0;
        bus.ld_wid  = 2'd0;
        bus.ld_sign = 1'b0;
        bus.st_req  = 1'b0;
        bus.st_addr = '0;
        bus.st_wid  = 2'd0;
        bus.st_data = '0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_if_done", bus.if_done, 1'b0);
        chkb("rst_ld_done", bus.ld_done, 1'b0);
        chkb("rst_st_done", bus.st_done, 1'b0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_ld_data", bus.ld_data, 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chkb("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_mem_dout", {24'h0, bus.mem_dout}, 32'h0);

        // Fetch at 0x100
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        cyc(1);
        chkb("f_busy", bus.busy, 1'b1);
        chk("f_a0", bus.mem_a, 32'h100);
        cyc(1);
        chk("f_a1", bus.mem_a, 32'h101);
        cyc(1);
        chk("f_a2", bus.mem_a, 32'h102);
        cyc(1);
        chk("f_a3", bus.mem_a, 32'h103);
        cyc(1);
        chk("f_a4", bus.mem_a, 32'h0);
        chkb("f_early", bus.if_done, 1'b0);
        cyc(1);
        chkb("f_done", bus.if_done, 1'b1);
        chk("f_data", bus.if_data, 32'h0000_0513);
        bus.if_req = 1'b0;
        cyc(1);
        chkb("f_pulse", bus.if_done, 1'b0);
        chkb("f_idle", bus.busy, 1'b0);

        // Signed byte load at 0x20
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h20;
        bus.ld_wid  = 2'd0;
        bus.ld_sign = 1'b1;
        cyc(1);
        chk("lb_a0", bus.mem_a, 32'h20);
        cyc(1);
        chkb("lb_early", bus.ld_done, 1'b0);
        cyc(1);
        chkb("lb_done", bus.ld_done, 1'b1);
        chk("lb_data", bus.ld_data, 32'hFFFF_FF80);
        bus.ld_req = 1'b0;
        cyc(1);
        chkb("lb_pulse", bus.ld_done, 1'b0);

        // Unsigned half load at 0x22
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h22;
        bus.ld_wid  = 2'd1;
        bus.ld_sign = 1'b0;
        cyc(3);
        chkb("lh_early", bus.ld_done, 1'b0);
        cyc(1);
        chkb("lh_done", bus.ld_done, 1'b1);
        chk("lh_data", bus.ld_data, 32'h0000_8001);
        bus.ld_req = 1'b0;
        cyc(1);

        // All three at once: ld, then if, then st
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h30;
        bus.ld_wid  = 2'd0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.st_req  = 1'b1;
        bus.st_addr = 32'h50;
        bus.st_wid  = 2'd0;
        bus.st_data = 32'h0000_00A5;
        cyc(1);
        chk("ar_ld_a", bus.mem_a, 32'h30);
        chkb("ar_ld_wr", bus.mem_wr, 1'b0);
        cyc(2);
        chkb("ar_ld_done", bus.ld_done, 1'b1);
        chk("ar_ld_data", bus.ld_data, 32'h0000_005A);
        bus.ld_req = 1'b0;
        cyc(1);
        chk("ar_if_a", bus.mem_a, 32'h40);
        cyc(5);
        chkb("ar_if_done", bus.if_done, 1'b1);
        chk("ar_if_data", bus.if_data, 32'h4433_2211);
        bus.if_req = 1'b0;
        cyc(1);
        chkb("ar_st_wr", bus.mem_wr, 1'b1);
        chk("ar_st_a", bus.mem_a, 32'h50);
        chk("ar_st_d", {24'h0, bus.mem_dout}, 32'hA5);
        cyc(1);
        chkb("ar_st_done", bus.st_done, 1'b1);
        bus.st_req = 1'b0;
        cyc(1);

        // Aging: loads and fetches keep requesting, store wins third grant
        bus.ld_req  = 1'b1;
        bus.if_req  = 1'b1;
        bus.st_req  = 1'b1;
        bus.st_addr = 32'h51;
        bus.st_data = 32'h0000_003C;
        cyc(1);
        chk("ag_g1", bus.mem_a, 32'h30);
        cyc(2);
        chkb("ag_ld_done", bus.ld_done, 1'b1);
        cyc(1);
        chk("ag_g2", bus.mem_a, 32'h40);
        cyc(5);
        chkb("ag_if_done", bus.if_done, 1'b1);
        cyc(1);
        chkb("ag_g3_wr", bus.mem_wr, 1'b1);
        chk("ag_g3_a", bus.mem_a, 32'h51);
        chk("ag_g3_d", {24'h0, bus.mem_dout}, 32'h3C);
        cyc(1);
        chkb("ag_st_done", bus.st_done, 1'b1);
        bus.st_req = 1'b0;
        bus.if_req = 1'b0;
        cyc(1);
        chk("ag_g4", bus.mem_a, 32'h30);
        cyc(2);
        chkb("ag_ld2_done", bus.ld_done, 1'b1);
        bus.ld_req = 1'b0;
        cyc(1);

        // Word store across the address wrap
        bus.st_req  = 1'b1;
        bus.st_addr = 32'hFFFF_FFFE;
        bus.st_wid  = 2'd2;
        bus.st_data = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chkb("sw_wr", bus.mem_wr, 1'b1);
            chk("sw_a", bus.mem_a, wa[k]);
            chk("sw_d", {24'h0, bus.mem_dout}, {24'h0, wd[k]});
        end
        cyc(1);
        chkb("sw_done", bus.st_done, 1'b1);
        chkb("sw_nowr", bus.mem_wr, 1'b0);
        bus.st_req = 1'b0;
        cyc(1);

        // Store with wid 3 and a flush in WR cycle 2
        bus.st_req  = 1'b1;
        bus.st_addr = 32'h60;
        bus.st_wid  = 2'd3;
        bus.st_data = 32'h0403_0201;
        cyc(1);
        chk("sc_a0", bus.mem_a, 32'h60);
        cyc(1);
        clr = 1'b1;
        chk("sc_a1", bus.mem_a, 32'h61);
        cyc(1);
        clr = 1'b0;
        chkb("sc_wr2", bus.mem_wr, 1'b1);
        chk("sc_d2", {24'h0, bus.mem_dout}, 32'h03);
        cyc(1);
        chk("sc_a3", bus.mem_a, 32'h63);
        chk("sc_d3", {24'h0, bus.mem_dout}, 32'h04);
        cyc(1);
        chkb("sc_done", bus.st_done, 1'b1);
        bus.st_req = 1'b0;
        cyc(1);

        // Flush a fetch in RD cycle 3
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        cyc(3);
        clr = 1'b1;
        bus.if_req = 1'b0;
        cyc(1);
        clr = 1'b0;
        chkb("fc_idle", bus.busy, 1'b0);
        chk("fc_a", bus.mem_a, 32'h0);
        cyc(1);
        chkb("fc_nd5", bus.if_done, 1'b0);
        cyc(1);
        chkb("fc_nd6", bus.if_done, 1'b0);

        // Flush coinciding with the final read cycle
        bus.if_req = 1'b1;
        cyc(5);
        clr = 1'b1;
        bus.if_req = 1'b0;
        cyc(1);
        clr = 1'b0;
        chkb("fn_nodone", bus.if_done, 1'b0);
        chkb("fn_idle", bus.busy, 1'b0);

        // Flush in IDLE masks a read grant
        bus.if_req = 1'b1;
        clr = 1'b1;
        cyc(1);
        chkb("fi_mask", bus.busy, 1'b0);
        clr = 1'b0;
        cyc(1);
        chkb("fi_grant", bus.busy, 1'b1);
        chk("fi_a", bus.mem_a, 32'h40);
        cyc(5);
        chkb("fi_done", bus.if_done, 1'b1);
        chk("fi_data", bus.if_data, 32'h4433_2211);
        bus.if_req = 1'b0;
        cyc(1);

        // Stall three cycles in the middle of a signed half load
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h22;
        bus.ld_wid  = 2'd1;
        bus.ld_sign = 1'b1;
        cyc(1);
        chk("st_a0", bus.mem_a, 32'h22);
        cyc(1);
        rdy = 1'b0;
        #1;
        chk("st_hold1", bus.mem_a, 32'h23);
        cyc(2);
        chk("st_hold3", bus.mem_a, 32'h23);
        chkb("st_nd", bus.ld_done, 1'b0);
        cyc(1);
        rdy = 1'b1;
        cyc(1);
        chkb("st_early", bus.ld_done, 1'b0);
        cyc(1);
        chkb("st_done", bus.ld_done, 1'b1);
        chk("st_data", bus.ld_data, 32'hFFFF_8001);
        bus.ld_req = 1'b0;
        cyc(1);
        chkb("st_pulse", bus.ld_done, 1'b0);

        // Stalled byte store and a stalled done pulse
        bus.st_req  = 1'b1;
        bus.st_addr = 32'h70;
        bus.st_wid  = 2'd0;
        bus.st_data = 32'h0000_0077;
        cyc(1);
        rdy = 1'b0;
        #1;
        chkb("ss_wr_gated", bus.mem_wr, 1'b0);
        chk("ss_a", bus.mem_a, 32'h70);
        cyc(1);
        rdy = 1'b1;
        #1;
        chkb("ss_wr", bus.mem_wr, 1'b1);
        cyc(1);
        rdy = 1'b0;
        #1;
        chkb("ss_done_gated", bus.st_done, 1'b0);
        cyc(1);
        rdy = 1'b1;
        #1;
        chkb("ss_done", bus.st_done, 1'b1);
        bus.st_req = 1'b0;
        cyc(1);
        chkb("ss_pulse", bus.st_done, 1'b0);
        chk("ss_ram", {24'h0, ram[8'h70]}, 32'h77);
        chkb("end_idle", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
